async_fifo_read_stream: RTL and testbench
=========================================

// Module: async_fifo_read_stream
// PURPOSE
//  Read-domain consumer of the async FIFO: turns its p_read_en/p_read_empty/p_read_data port into a
//  registered valid/ready stream. Prefetches words into a small output buffer so that, with m_ready
//  held high, one word per read_clk cycle is delivered despite the FIFO's 1-cycle read-data latency.
//  Sits directly between the async FIFO read port and read-domain consumers.
// PARAMETERS
//  DATA_WIDTH  8   width of FIFO word and m_data
//  BUF_DEPTH   2   output buffer entries; legal 2..8; 2 is the minimum for full throughput
//  CNT_WIDTH   32  width of delivered-word counter o_word_count
// PORTS
//  read_clk      in   1              read-domain clock; all logic on posedge
//  read_rst_n    in   1              asynchronous assert, active-low reset
//  p_read_empty  in   1              FIFO empty flag (registered, read domain)
//  p_read_data   in   DATA_WIDTH     FIFO read data; valid in the cycle after an accepted p_read_en
//  p_read_en     out  1              read request to FIFO
//  i_flush       in   1              synchronous flush: discard buffered and in-flight words
//  m_valid       out  1              stream word available
//  m_ready       in   1              consumer accepts word when m_valid && m_ready
//  m_data        out  DATA_WIDTH     stream word (held stable while m_valid && !m_ready)
//  o_level       out  $clog2(BUF_DEPTH+1)  words currently held in output buffer
//  o_word_count  out  CNT_WIDTH      words delivered (pops) since reset, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Single clock read_clk; read_rst_n asserts asynchronously, deasserts with read_clk.
//  - Reset values: p_read_en=0, m_valid=0, m_data=0, o_level=0, o_word_count=0, inflight=0, discard=0.
//  - pop = m_valid && m_ready. push = inflight (word requested last cycle) && !discard.
//  - p_read_en (combinational from registered state + p_read_empty + m_ready) =
//      !p_read_empty && !i_flush && (o_level + inflight - pop) < BUF_DEPTH.
//    Never asserted while p_read_empty=1 or during reset.
//  - inflight <= p_read_en each edge; word arriving on p_read_data is captured into buffer tail at the
//    edge ending the cycle after the request.
//  - Latency: p_read_en high at edge k -> data captured edge k+1 -> m_valid high after edge k+1 (empty
//    buffer case). m_data driven from buffer head register; no combinational path p_read_data->m_data.
//  - Ordering strictly FIFO; no word lost or duplicated except by i_flush.
//  - Simultaneous push and pop: level unchanged; pop of head and write of tail in same edge;
//    push into empty buffer with pop=0 is the only way m_valid rises.
//  - Level arithmetic: o_level_next = o_level + push - pop; never exceeds BUF_DEPTH (guaranteed by
//    p_read_en credit rule), never underflows (pop requires m_valid).
//  - Buffer pointers wrap modulo BUF_DEPTH; o_word_count increments on pop, wraps to 0 silently.
//  - m_valid/m_data stable while m_valid && !m_ready (standard valid/ready hold rule).
//  - i_flush=1 at an edge: o_level->0, m_valid->0, pointers reset, p_read_en=0 that cycle;
//    discard <= inflight so a word requested the cycle before flush is dropped on arrival.
//    A pop coincident with flush is still counted in o_word_count. Flush does not clear o_word_count.
//  - Reset mid-operation: all state to reset values immediately; any outstanding FIFO read is
//    abandoned (FIFO read domain is reset together with this block).
// STRUCTURE
//  - async_fifo_pkg: shared typedef word_t (logic [DATA_WIDTH-1:0]) and constant
//    ASYNC_FIFO_OUT_BUF_MIN = 2; reused by the write-side stage.
//  - One sub-module async_fifo_out_buf: BUF_DEPTH-entry register FIFO (push, pop, clear, head data,
//    level). Top level holds credit logic, inflight/discard flags, word counter.
// TESTING
//  - Reset: hold read_rst_n=0 mid-clock with FIFO non-empty -> p_read_en=0, m_valid=0, o_level=0,
//    o_word_count=0 immediately, no read issued until first edge after release.
//  - Streaming: FIFO holds 16 words 0x00..0x0F, m_ready=1 -> m_data 0x00..0x0F on 16 consecutive
//    cycles, first m_valid 2 edges after first p_read_en, o_word_count=16.
//  - Backpressure: m_ready=0 for 10 cycles with FIFO non-empty -> exactly BUF_DEPTH (2) reads issued,
//    o_level=2, m_data holds first word; release -> order preserved, no gap after refill.
//  - Empty boundary: FIFO empties after 3 words, m_ready=1 -> p_read_en never high while
//    p_read_empty=1, m_valid drops after word 3, resumes when p_read_empty falls.
//  - Flush with in-flight: i_flush=1 the cycle after a p_read_en with o_level=1 -> o_level=0,
//    m_valid=0, arriving word discarded; next delivered word is the following FIFO entry.
//  - Counter wrap: CNT_WIDTH=4, deliver 17 words -> o_word_count reads 1.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Types and constants shared by the async FIFO read- and write-side stream stages.
package async_fifo_pkg;
    localparam int WORD_WIDTH             = 8;
    localparam int ASYNC_FIFO_OUT_BUF_MIN = 2;

    typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/async_fifo_read_stream_if.sv
// FIFO read port plus the outgoing valid/ready stream; master is the read-stream stage.
interface async_fifo_read_stream_if
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_WIDTH
);
    logic                  p_read_empty;
    logic [DATA_WIDTH-1:0] p_read_data;
    logic                  p_read_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  p_read_empty, p_read_data, m_ready,
        output p_read_en, m_valid, m_data
    );

    modport slave (
        output p_read_empty, p_read_data, m_ready,
        input  p_read_en, m_valid, m_data
    );
endinterface

// File: rtl/async_fifo_out_buf.sv
// Small register FIFO holding prefetched words; head is always a stored register, never the input.
module async_fifo_out_buf #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUF_DEPTH  = 2,
    localparam int PW         = $clog2(BUF_DEPTH),
    localparam int LW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [LW-1:0]         level
);
    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0]                        rd_ptr, wr_ptr;
    logic [LW-1:0]                        cnt;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // clear wins over push: a word landing on the clear edge is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + LW'(push) - LW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign level = cnt;
endmodule

// File: rtl/async_fifo_read_stream.sv
// Read-domain consumer of the async FIFO: prefetches into a small buffer and presents valid/ready.
module async_fifo_read_stream
    import async_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = WORD_WIDTH,
    parameter  int BUF_DEPTH  = ASYNC_FIFO_OUT_BUF_MIN,
    parameter  int CNT_WIDTH  = 32,
    localparam int LW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                   read_clk,
    input  logic                   read_rst_n,
    async_fifo_read_stream_if.master bus,
    input  logic                   i_flush,
    output logic [LW-1:0]          o_level,
    output logic [CNT_WIDTH-1:0]   o_word_count
);
    localparam int OW = LW + 1;

    logic          inflight, discard;
    logic          pop, push;
    logic [OW-1:0] occ;

    assign pop  = bus.m_valid & bus.m_ready;
    assign push = inflight & ~discard;

    // Credit: buffered + in-flight words after this cycle's pop must leave room for one more
    assign occ           = {1'b0, o_level} + OW'(inflight) - OW'(pop);
    assign bus.p_read_en = read_rst_n & ~bus.p_read_empty & ~i_flush & (occ < OW'(BUF_DEPTH));
    assign bus.m_valid   = (o_level != '0);

    async_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .clear     (i_flush),
        .push      (push),
        .push_data (bus.p_read_data),
        .pop       (pop),
        .head      (bus.m_data),
        .level     (o_level)
    );

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            inflight     <= 1'b0;
            discard      <= 1'b0;
            o_word_count <= '0;
        end else begin
            inflight     <= bus.p_read_en;
            discard      <= i_flush & inflight;
            o_word_count <= o_word_count + CNT_WIDTH'(pop);
        end
    end
endmodule

// File: tb/tb_async_fifo_read_stream.sv
// Directed bench: FIFO read-port model, scoreboard queue filled by stimulus, negedge monitor.
module tb_async_fifo_read_stream;
    import async_fifo_pkg::*;

    localparam int DW = 8;
    localparam int BD = 2;
    localparam int CW = 4;
    localparam int LW = $clog2(BD + 1);

    logic          read_clk   = 1'b0;
    logic          read_rst_n = 1'b0;
    logic          i_flush    = 1'b0;
    logic [LW-1:0] o_level;
    logic [CW-1:0] o_word_count;

    async_fifo_read_stream_if #(.DATA_WIDTH(DW)) bus();

    async_fifo_read_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .CNT_WIDTH  (CW)
    ) dut (
        .read_clk     (read_clk),
        .read_rst_n   (read_rst_n),
        .bus          (bus),
        .i_flush      (i_flush),
        .o_level      (o_level),
        .o_word_count (o_word_count)
    );

    always #5 read_clk = ~read_clk;

    // FIFO read port: registered empty flag, data one cycle after an accepted read
    word_t fmem [0:255];
    int    fwr = 0;
    int    frd = 0;

    always @(posedge read_clk) begin
        if (bus.p_read_en) begin
            bus.p_read_data  <= fmem[frd[7:0]];
            frd              <= frd + 1;
            bus.p_read_empty <= (frd + 1 >= fwr);
        end else begin
            bus.p_read_empty <= (frd >= fwr);
        end
    end

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int first, input int n, input int skip);
        for (int i = 0; i < n; i++) begin
            fmem[fwr[7:0]] = word_t'(first + i);
            fwr            = fwr + 1;
            if (i >= skip) exp_q.push_back(word_t'(first + i));
        end
    endtask

    task automatic wait_level(input int lv, input string name);
        for (int k = 0; k < 30 && o_level != LW'(lv); k++) @(negedge read_clk);
        chk(name, 32'(o_level), lv);
    endtask

    task automatic wait_count(input int c, input string name);
        for (int k = 0; k < 40 && o_word_count != CW'(c); k++) @(negedge read_clk);
        chk(name, 32'(o_word_count), c % (1 << CW));
    endtask

    // Monitor: compares every handshake against the scoreboard
    initial begin
        forever begin
            @(negedge read_clk);
            #2;
            if (read_rst_n) begin
                if (bus.p_read_empty) chk("rd_en_while_empty", 32'(bus.p_read_en), 0);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%0h required=none t=%0t", bus.m_data, $time);
                    end else begin
                        chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        bus.m_ready = 1'b1;

        // Reset held with a non-empty FIFO
        load(8'h00, 16, 0);
        repeat (3) @(negedge read_clk);
        chk("rst_rd_en", 32'(bus.p_read_en), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_count", 32'(o_word_count), 0);
        chk("rst_data", 32'(bus.m_data), 0);
        chk("rst_no_read", frd, 0);

        // Streaming 0x00..0x0F at one word per cycle
        read_rst_n = 1'b1;
        #1 chk("rel_rd_en", 32'(bus.p_read_en), 1);
        @(negedge read_clk) chk("lat_valid_low", 32'(bus.m_valid), 0);
        @(negedge read_clk) chk("lat_valid_high", 32'(bus.m_valid), 1);
        for (int i = 0; i < 15; i++) @(negedge read_clk) chk("stream_gap", 32'(bus.m_valid), 1);
        @(negedge read_clk);
        chk("stream_end_valid", 32'(bus.m_valid), 0);
        chk("stream_count", 32'(o_word_count), 16 % (1 << CW));

        // Backpressure: exactly BUF_DEPTH reads, head held
        bus.m_ready = 1'b0;
        load(8'h30, 6, 0);
        f0 = frd;
        repeat (10) @(negedge read_clk);
        chk("bp_reads", frd - f0, BD);
        chk("bp_level", 32'(o_level), BD);
        chk("bp_hold_data", 32'(bus.m_data), 32'h30);
        chk("bp_hold_valid", 32'(bus.m_valid), 1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge read_clk);
            if (i == 0) chk("cnt_wrap_17", 32'(o_word_count), 1);
            chk("bp_no_gap", 32'(bus.m_valid), 1);
        end
        @(negedge read_clk) chk("bp_count", 32'(o_word_count), 22 % (1 << CW));

        // FIFO runs empty after 3 words, then refills
        load(8'h20, 3, 0);
        wait_count(25, "empty_count");
        for (int i = 0; i < 3; i++) begin
            chk("empty_valid_low", 32'(bus.m_valid), 0);
            @(negedge read_clk);
        end
        load(8'h23, 1, 0);
        wait_count(26, "empty_resume");

        // Flush with a word in flight and one buffered
        bus.m_ready = 1'b0;
        f0 = frd;
        load(8'h40, 3, 2);
        wait_level(1, "fl_level1");
        chk("fl_credit_full", 32'(bus.p_read_en), 0);
        i_flush = 1'b1;
        #1 chk("fl_no_read", 32'(bus.p_read_en), 0);
        @(negedge read_clk);
        chk("fl_level0", 32'(o_level), 0);
        chk("fl_valid0", 32'(bus.m_valid), 0);
        i_flush = 1'b0;
        wait_level(1, "fl_refill");
        chk("fl_next_word", 32'(bus.m_data), 32'h42);
        chk("fl_reads", frd - f0, 3);
        bus.m_ready = 1'b1;
        wait_count(27, "fl_count");

        // Reset in the middle of backpressured operation
        bus.m_ready = 1'b0;
        load(8'h50, 4, 2);
        wait_level(2, "mr_level2");
        repeat (2) @(negedge read_clk);
        #1 read_rst_n = 1'b0;
        #1;
        chk("mr_rd_en", 32'(bus.p_read_en), 0);
        chk("mr_valid", 32'(bus.m_valid), 0);
        chk("mr_level", 32'(o_level), 0);
        chk("mr_count", 32'(o_word_count), 0);
        f0 = frd;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge read_clk);
        chk("mr_no_read", frd, f0);
        read_rst_n = 1'b1;
        wait_count(2, "mr_resume");

        repeat (3) @(negedge read_clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
